// File: rtl/cavlc_pkg.sv
// Shared CAVLC level-decode types and constants.
package cavlc_pkg;

   typedef enum logic [1:0] {IDLE, T1, LEVEL, ERR} state_t;

   localparam int unsigned MAX_PREFIX    = 15;
   localparam int unsigned ESC_SUFFIX_14 = 4;
   localparam int unsigned ESC_SUFFIX_15 = 12;

   // |level| above this value grows suffixLength; sl is always >= 1 here
   function automatic logic [13:0] sl_threshold(input logic [2:0] sl);
      return 14'd3 << (sl - 3'd1);
   endfunction

endpackage

// File: rtl/cavlc_prefix_finder.sv
// Leading-zero counter over the top 16 window bits (level_prefix).
module cavlc_prefix_finder (
   input  logic [15:0] bits,
   output logic [4:0]  count,
   output logic        all_zero
);

   always_comb begin
      count = 5'd16;
      for (int unsigned i = 0; i < 16; i++)
         if (bits[i]) count = 5'(15 - i);
   end

   assign all_zero = (bits == '0);

endmodule

// File: rtl/level_decode_param.sv
// CAVLC coefficient level decoder: trailing-ones then prefix/suffix coded levels,
// one level per cycle into a single-entry valid/ready output register.
module level_decode_param
   import cavlc_pkg::*;
#(
   parameter int MAX_COEFF = 16,
   parameter int LEVEL_W   = 16,
   parameter int WIN_W     = 32
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      Start,
   input  logic [4:0]                TotalCoeff,
   input  logic [1:0]                TrailingOnes,
   input  logic [WIN_W-1:0]          BitstreamShifted,
   output logic [4:0]                NumShift,
   output logic                      ShiftEn,
   output logic signed [LEVEL_W-1:0] LevelOut,
   output logic                      LevelValid,
   input  logic                      LevelReady,
   output logic                      Done,
   output logic                      Error
);

   state_t state_q, state_d;
   logic [2:0] sl_q, sl_d;
   logic [4:0] rem_q, rem_d;
   logic [1:0] t1_q, t1_d;
   logic first_q, first_d, t1s_q, t1s_d;
   logic val_q, val_d, last_q, last_d;
   logic done0_q, done0_d, err_q, err_d;
   logic signed [LEVEL_W-1:0] level_q, level_d;

   logic [4:0] prefix;
   logic       no_one;

   cavlc_prefix_finder u_prefix (
      .bits     (BitstreamShifted[WIN_W-1 -: 16]),
      .count    (prefix),
      .all_zero (no_one)
   );

   logic [3:0]  ssize;
   logic [11:0] suffix;
   logic [13:0] code, mag;
   logic [2:0]  sl_a, sl_up;
   logic signed [LEVEL_W-1:0] mag_s;

   always_comb begin
      if (prefix == 5'd14 && sl_q == '0) ssize = 4'(ESC_SUFFIX_14);
      else if (prefix == 5'(MAX_PREFIX)) ssize = 4'(ESC_SUFFIX_15);
      else                               ssize = {1'b0, sl_q};
      // suffix sits right after the terminating one, right-justified to ssize bits
      suffix = 12'((BitstreamShifted << (prefix + 5'd1)) >> (WIN_W - 12)) >> (4'd12 - ssize);
      code = (14'(prefix[3:0]) << sl_q) + 14'(suffix);
      if (prefix == 5'(MAX_PREFIX) && sl_q == '0) code = code + 14'd15;
      if (first_q && t1s_q) code = code + 14'd2;
      mag   = code[0] ? (code + 14'd1) >> 1 : (code + 14'd2) >> 1;
      mag_s = LEVEL_W'(mag);
      sl_a  = (sl_q == '0) ? 3'd1 : sl_q;
      sl_up = (mag > sl_threshold(sl_a) && sl_a < 3'd6) ? sl_a + 3'd1 : sl_a;
   end

   logic accept, slot_free, active;
   assign accept    = val_q & LevelReady;
   assign slot_free = ~val_q | LevelReady;
   assign active    = rem_q != '0;

   always_comb begin
      state_d  = state_q;
      sl_d     = sl_q;
      rem_d    = rem_q;
      t1_d     = t1_q;
      first_d  = first_q;
      t1s_d    = t1s_q;
      val_d    = val_q & ~LevelReady;
      last_d   = last_q;
      level_d  = level_q;
      done0_d  = 1'b0;
      err_d    = err_q;
      ShiftEn  = 1'b0;
      NumShift = '0;
      case (state_q)
         IDLE: if (Start) begin
            err_d = 1'b0;
            if ({1'b0, TotalCoeff} > 6'(MAX_COEFF) || {3'b0, TrailingOnes} > TotalCoeff) begin
               state_d = ERR;
               err_d   = 1'b1;
            end else if (TotalCoeff == '0) begin
               done0_d = 1'b1;
            end else begin
               state_d = (TrailingOnes != '0) ? T1 : LEVEL;
               rem_d   = TotalCoeff;
               t1_d    = TrailingOnes;
               first_d = 1'b1;
               t1s_d   = TrailingOnes != 2'd3;
               sl_d    = (TotalCoeff > 5'd10 && TrailingOnes != 2'd3) ? 3'd1 : 3'd0;
            end
         end
         T1: if (active && slot_free) begin
            ShiftEn  = 1'b1;
            NumShift = 5'd1;
            val_d    = 1'b1;
            last_d   = rem_q == 5'd1;
            level_d  = BitstreamShifted[WIN_W-1] ? LEVEL_W'('1) : LEVEL_W'(1);
            rem_d    = rem_q - 5'd1;
            t1_d     = t1_q - 2'd1;
            if (t1_q == 2'd1 && rem_q != 5'd1) state_d = LEVEL;
         end else if (accept && last_q) begin
            state_d = IDLE;
         end
         LEVEL: if (active && slot_free) begin
            if (no_one) begin
               state_d = ERR;
               err_d   = 1'b1;
            end else begin
               ShiftEn  = 1'b1;
               NumShift = prefix + 5'd1 + {1'b0, ssize};
               val_d    = 1'b1;
               last_d   = rem_q == 5'd1;
               level_d  = code[0] ? -mag_s : mag_s;
               rem_d    = rem_q - 5'd1;
               first_d  = 1'b0;
               sl_d     = sl_up;
            end
         end else if (accept && last_q) begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         sl_q    <= '0;
         rem_q   <= '0;
         t1_q    <= '0;
         first_q <= 1'b0;
         t1s_q   <= 1'b0;
         val_q   <= 1'b0;
         last_q  <= 1'b0;
         level_q <= '0;
         done0_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sl_q    <= sl_d;
         rem_q   <= rem_d;
         t1_q    <= t1_d;
         first_q <= first_d;
         t1s_q   <= t1s_d;
         val_q   <= val_d;
         last_q  <= last_d;
         level_q <= level_d;
         done0_q <= done0_d;
         err_q   <= err_d;
      end
   end

   assign LevelOut   = level_q;
   assign LevelValid = val_q;
   assign Error      = err_q;
   assign Done       = done0_q | (accept & last_q);

endmodule

// File: tb/tb_level_decode_param.sv
// Bench for level_decode_param: levels are chosen first, encoded into a CAVLC
// bitstream by an encoder model, then the decoded stream is compared back.
module tb_level_decode_param;

   logic               Clk = 1'b0;
   logic               Reset, Start, LevelReady;
   logic [4:0]         TotalCoeff;
   logic [1:0]         TrailingOnes;
   logic [31:0]        BitstreamShifted;
   logic [4:0]         NumShift;
   logic               ShiftEn, LevelValid, Done, Error;
   logic signed [15:0] LevelOut;

   int n_vec = 0;
   int n_err = 0;

   bit bits_q[$];
   int exp_lvl[$];
   int exp_len[$];
   int lv[$];

   always #5 Clk = ~Clk;

   level_decode_param #(.MAX_COEFF(16), .LEVEL_W(16), .WIN_W(32)) dut (
      .Clk              (Clk),
      .Reset            (Reset),
      .Start            (Start),
      .TotalCoeff       (TotalCoeff),
      .TrailingOnes     (TrailingOnes),
      .BitstreamShifted (BitstreamShifted),
      .NumShift         (NumShift),
      .ShiftEn          (ShiftEn),
      .LevelOut         (LevelOut),
      .LevelValid       (LevelValid),
      .LevelReady       (LevelReady),
      .Done             (Done),
      .Error            (Error)
   );

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // CAVLC encoder: levels in lv[] -> bits_q, with expected levels and code lengths
   task automatic encode(input int tc, input int t1);
      int sl, code, pfx, sfx, ssz, mag;
      bits_q.delete(); exp_lvl.delete(); exp_len.delete();
      sl = (tc > 10 && t1 < 3) ? 1 : 0;
      for (int i = 0; i < tc; i++) begin
         exp_lvl.push_back(lv[i]);
         if (i < t1) begin
            bits_q.push_back(lv[i] < 0);
            exp_len.push_back(1);
         end else begin
            code = (lv[i] > 0) ? 2 * lv[i] - 2 : -2 * lv[i] - 1;
            if (i == t1 && t1 < 3) code -= 2;
            if (sl == 0) begin
               if (code < 14)      begin pfx = code; ssz = 0;  sfx = 0;         end
               else if (code < 30) begin pfx = 14;   ssz = 4;  sfx = code - 14; end
               else                begin pfx = 15;   ssz = 12; sfx = code - 30; end
            end else if (code < (15 << sl)) begin
               pfx = code >> sl; ssz = sl; sfx = code % (1 << sl);
            end else begin
               pfx = 15; ssz = 12; sfx = code - (15 << sl);
            end
            repeat (pfx) bits_q.push_back(1'b0);
            bits_q.push_back(1'b1);
            for (int b = ssz - 1; b >= 0; b--) bits_q.push_back(sfx[b]);
            exp_len.push_back(pfx + 1 + ssz);
            mag = (lv[i] < 0) ? -lv[i] : lv[i];
            if (sl == 0) sl = 1;
            if (mag > (3 << (sl - 1)) && sl < 6) sl++;
         end
      end
   endtask

   task automatic gen_levels(input int tc, input int t1);
      int mag;
      lv.delete();
      for (int i = 0; i < tc; i++) begin
         if (i < t1) lv.push_back($urandom_range(0, 1) ? -1 : 1);
         else begin
            mag = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2000))
                                              : int'($urandom_range(1, 12));
            if (i == t1 && t1 < 3 && mag < 2) mag = 2;
            lv.push_back($urandom_range(0, 1) ? -mag : mag);
         end
      end
   endtask

   function automatic logic [31:0] window();
      logic [31:0] w;
      for (int k = 0; k < 32; k++)
         w[31-k] = (k < bits_q.size()) ? bits_q[k] : 1'($urandom_range(0, 1));
      return w;
   endfunction

   // mode 0: always ready, 1: random ready, 2: three-cycle stall on the first level
   task automatic run_block(input int tc, input int t1, input int mode, input string tag);
      int cyc, shift, got, stall_left;
      bit stalled, fin;
      logic signed [15:0] held;
      encode(tc, t1);
      BitstreamShifted = window();
      TotalCoeff = 5'(tc); TrailingOnes = 2'(t1); LevelReady = 1'b1; Start = 1'b1;
      @(posedge Clk); #1 Start = 1'b0;
      cyc = 0; got = 0; fin = 0; stalled = 0; held = '0;
      stall_left = (mode == 2) ? 3 : 0;
      while (!fin && cyc < 400) begin
         cyc++;
         if (mode == 1) LevelReady = 1'($urandom_range(0, 1));
         else if (mode == 2 && LevelValid && stall_left > 0) begin
            LevelReady = 1'b0; stall_left--;
         end else LevelReady = 1'b1;
         BitstreamShifted = window();
         @(negedge Clk);
         if (cyc == 1) check({tag, " error clear"}, Error, 0);
         if (stalled) begin
            check({tag, " hold valid"}, LevelValid, 1);
            check({tag, " hold level"}, LevelOut, held);
         end
         if (LevelValid && !LevelReady) check({tag, " stall shiften"}, ShiftEn, 0);
         shift = 0;
         if (ShiftEn) begin
            if (exp_len.size() == 0) check({tag, " extra shift"}, ShiftEn, 0);
            else check({tag, " numshift"}, NumShift, exp_len.pop_front());
            shift = int'(NumShift);
         end
         if (LevelValid && LevelReady) begin
            got++;
            if (exp_lvl.size() == 0) check({tag, " extra level"}, LevelValid, 0);
            else check({tag, " level"}, LevelOut, exp_lvl.pop_front());
            check({tag, " done"}, Done, got == tc);
            fin = (got == tc);
         end
         stalled = LevelValid && !LevelReady;
         held = LevelOut;
         @(posedge Clk); #1;
         repeat (shift) if (bits_q.size() != 0) void'(bits_q.pop_front());
      end
      check({tag, " finished"}, fin, 1);
      if (mode == 0) check({tag, " cycles"}, cyc, tc + 1);
      check({tag, " bits left"}, bits_q.size(), 0);
   endtask

   task automatic do_reset(input string tag);
      Reset = 1'b1; Start = 1'b0; LevelReady = 1'b0;
      @(negedge Clk);
      check({tag, " numshift"}, NumShift, 0);
      check({tag, " shiften"}, ShiftEn, 0);
      check({tag, " level"}, LevelOut, 0);
      check({tag, " valid"}, LevelValid, 0);
      check({tag, " done"}, Done, 0);
      check({tag, " error"}, Error, 0);
      @(posedge Clk); #1 Reset = 1'b0;
   endtask

   task automatic bad_start(input int tc, input int t1, input string tag);
      TotalCoeff = 5'(tc); TrailingOnes = 2'(t1); Start = 1'b1;
      @(posedge Clk); #1 Start = 1'b0;
      @(negedge Clk);
      check({tag, " error"}, Error, 1);
      check({tag, " shiften"}, ShiftEn, 0);
      check({tag, " valid"}, LevelValid, 0);
      repeat (2) @(posedge Clk);
      #1;
   endtask

   initial begin
      int tc, t1;
      Reset = 1'b1; Start = 1'b0; LevelReady = 1'b0;
      TotalCoeff = '0; TrailingOnes = '0; BitstreamShifted = '0;
      do_reset("reset");

      lv = '{1, -1, -1};    run_block(3, 3, 0, "t1x3");
      lv = '{2};            run_block(1, 0, 0, "lvl2");
      lv = '{1, 1, 1, -10}; run_block(4, 3, 0, "esc14");
      lv = '{1, 1, 1, -16}; run_block(4, 3, 0, "esc15");
      gen_levels(6, 1);     run_block(6, 1, 2, "stall");

      TotalCoeff = '0; TrailingOnes = '0; LevelReady = 1'b1; Start = 1'b1;
      @(posedge Clk); #1 Start = 1'b0;
      @(negedge Clk);
      check("tc0 done", Done, 1);
      check("tc0 shiften", ShiftEn, 0);
      check("tc0 valid", LevelValid, 0);
      @(posedge Clk); #1;
      @(negedge Clk);
      check("tc0 done end", Done, 0);
      @(posedge Clk); #1;

      bad_start(17, 0, "tc17");
      bad_start(1, 2, "t1gt");
      gen_levels(16, 0);    run_block(16, 0, 0, "full16");

      TotalCoeff = 5'd4; TrailingOnes = '0; BitstreamShifted = 32'h0000_FFFF;
      LevelReady = 1'b1; Start = 1'b1;
      @(posedge Clk); #1 Start = 1'b0;
      @(negedge Clk);
      check("pfx16 shiften", ShiftEn, 0);
      check("pfx16 valid", LevelValid, 0);
      @(posedge Clk); #1;
      @(negedge Clk);
      check("pfx16 error", Error, 1);
      check("pfx16 shiften2", ShiftEn, 0);
      check("pfx16 valid2", LevelValid, 0);
      @(posedge Clk); #1;
      do_reset("err reset");

      gen_levels(5, 2);
      encode(5, 2);
      BitstreamShifted = window();
      TotalCoeff = 5'd5; TrailingOnes = 2'd2; LevelReady = 1'b0; Start = 1'b1;
      @(posedge Clk); #1 Start = 1'b0;
      repeat (2) @(posedge Clk);
      #2;
      do_reset("mid reset");
      gen_levels(7, 2);     run_block(7, 2, 0, "after reset");

      for (int n = 0; n < 40; n++) begin
         tc = $urandom_range(1, 16);
         t1 = $urandom_range(0, (tc < 3) ? tc : 3);
         gen_levels(tc, t1);
         run_block(tc, t1, n % 2, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
